// File: rtl/spi_slave_8bit.sv
// SPI mode-0 slave, 8-bit MSB-first frames, with one-byte tx holding buffer.
// Define SPI_SLAVE_ECHO_EN to echo the last received byte when no tx byte is queued.
module spi_slave_8bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sclk,
    input  logic       cs_bar,
    input  logic       din_mosi,
    output logic       dout_miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t r_state;

    logic [SYNC_STAGES-1:0] r_sclkSync;
    logic [SYNC_STAGES-1:0] r_csSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic                   r_sclkPrev;
    logic                   r_csPrev;

    logic [7:0] r_txBuf;
    logic       r_txFull;
    logic [7:0] r_txShift;
    logic [7:0] r_rxShift;
    logic [7:0] r_rxData;
    logic [2:0] r_bitCnt;
    logic       r_miso;
    logic       r_rxValid;
    logic       r_frameErr;
    logic       r_busy;

    logic       w_sclkS;
    logic       w_csS;
    logic       w_mosiS;
    logic       w_sclkRise;
    logic       w_sclkFall;
    logic       w_csFall;
    logic [7:0] w_fillByte;
    logic [7:0] w_loadByte;

    // Synchronizers reset to the bus idle levels so no false edge follows reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclkSync <= '0;
            r_csSync   <= '1;
            r_mosiSync <= '0;
            r_sclkPrev <= 1'b0;
            r_csPrev   <= 1'b1;
        end else begin
            r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], sclk};
            r_csSync   <= {r_csSync[SYNC_STAGES-2:0], cs_bar};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], din_mosi};
            r_sclkPrev <= w_sclkS;
            r_csPrev   <= w_csS;
        end
    end

    assign w_sclkS    = r_sclkSync[SYNC_STAGES-1];
    assign w_csS      = r_csSync[SYNC_STAGES-1];
    assign w_mosiS    = r_mosiSync[SYNC_STAGES-1];
    assign w_sclkRise = w_sclkS & ~r_sclkPrev;
    assign w_sclkFall = ~w_sclkS & r_sclkPrev;
    assign w_csFall   = ~w_csS & r_csPrev;

`ifdef SPI_SLAVE_ECHO_EN
    assign w_fillByte = r_rxData;
`else
    assign w_fillByte = 8'h00;
`endif

    // A queued byte wins over a same-cycle tx_load; otherwise tx_load bypasses the buffer.
    assign w_loadByte = r_txFull ? r_txBuf : (tx_load ? tx_data : w_fillByte);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_txBuf    <= 8'h00;
            r_txFull   <= 1'b0;
            r_txShift  <= 8'h00;
            r_rxShift  <= 8'h00;
            r_rxData   <= 8'h00;
            r_bitCnt   <= 3'd0;
            r_miso     <= 1'b0;
            r_rxValid  <= 1'b0;
            r_frameErr <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rxValid  <= 1'b0;
            r_frameErr <= 1'b0;
            if (tx_load) begin
                r_txBuf  <= tx_data;
                r_txFull <= 1'b1;
            end
            if (w_csS) begin
                if (r_state == SHIFT && r_bitCnt != 3'd0) begin
                    r_frameErr <= 1'b1;
                end
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_miso    <= 1'b0;
                r_bitCnt  <= 3'd0;
                r_rxShift <= 8'h00;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_csFall) begin
                            r_state <= LOAD;
                            r_busy  <= 1'b1;
                        end
                    end
                    LOAD: begin
                        r_txShift <= w_loadByte;
                        r_miso    <= w_loadByte[7];
                        r_txFull  <= r_txFull & tx_load;
                        r_bitCnt  <= 3'd0;
                        r_state   <= SHIFT;
                    end
                    SHIFT: begin
                        if (w_sclkRise) begin
                            r_rxShift <= {r_rxShift[6:0], w_mosiS};
                            r_bitCnt  <= r_bitCnt + 3'd1;
                            if (r_bitCnt == 3'd7) begin
                                r_rxData  <= {r_rxShift[6:0], w_mosiS};
                                r_rxValid <= 1'b1;
                                r_state   <= LOAD;
                            end
                        // The fall before the first rise of a byte already shows its MSB.
                        end else if (w_sclkFall && r_bitCnt != 3'd0) begin
                            r_txShift <= {r_txShift[6:0], 1'b0};
                            r_miso    <= r_txShift[6];
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dout_miso = r_miso;
    assign tx_ready  = ~r_txFull;
    assign rx_data   = r_rxData;
    assign rx_valid  = r_rxValid;
    assign frame_err = r_frameErr;
    assign busy      = r_busy;

endmodule

// File: tb/tb_spi_slave_8bit.sv
// Self-checking bench for spi_slave_8bit: directed frames plus random frames against a byte-level model.
module tb_spi_slave_8bit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_bar = 1'b1;
    logic       din_mosi = 1'b0;
    logic       dout_miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    spi_slave_8bit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk      (sclk),
        .cs_bar    (cs_bar),
        .din_mosi  (din_mosi),
        .dout_miso (dout_miso),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse monitor, sampled on the falling clk edge.
    int         rxCount = 0;
    int         errCount = 0;
    int         bothCount = 0;
    logic [7:0] lastRxSeen = 8'h00;

    always @(negedge clk) begin
        if (rx_valid) begin
            rxCount    = rxCount + 1;
            lastRxSeen = rx_data;
        end
        if (frame_err) errCount = errCount + 1;
        if (rx_valid && frame_err) bothCount = bothCount + 1;
    end

    // Byte-level model: holding buffer, byte chosen at each load, last received byte.
    logic [7:0] mBuf = 8'h00;
    bit         mFull = 1'b0;
    logic [7:0] mLastRx = 8'h00;
    logic [7:0] mShift = 8'h00;

    function automatic logic [7:0] fillByte();
`ifdef SPI_SLAVE_ECHO_EN
        return mLastRx;
`else
        return 8'h00;
`endif
    endfunction

    task automatic modelLoad();
        mShift = mFull ? mBuf : fillByte();
        mFull  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadTx(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        mBuf  = v;
        mFull = 1'b1;
        checkOutput("tx_ready_low_after_load", tx_ready, 0);
    endtask

    task automatic csLow();
        @(negedge clk);
        cs_bar = 1'b0;
        repeat (10) @(negedge clk);
        modelLoad();
        checkOutput("busy_in_frame", busy, 1);
        checkOutput("tx_ready_after_load_state", tx_ready, mFull ? 0 : 1);
    endtask

    task automatic csHigh(input int expErr);
        int e0;
        e0 = errCount;
        @(negedge clk);
        cs_bar = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("frame_err_pulses", errCount - e0, expErr);
        checkOutput("busy_idle", busy, 0);
        checkOutput("miso_idle", dout_miso, 0);
    endtask

    // Mode-0 master: data set while sclk low, MISO sampled just before the rise.
    task automatic applyStimulus(input logic [7:0] mosi, input int nBits, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 7; i >= 8 - nBits; i--) begin
            din_mosi = mosi[i];
            #44;
            miso[i] = dout_miso;
            #6;
            sclk = 1'b1;
            #50;
            sclk = 1'b0;
        end
        din_mosi = 1'b0;
    endtask

    task automatic fullByte(input logic [7:0] mosi);
        logic [7:0] got;
        logic [7:0] expMiso;
        int         r0;
        expMiso = mShift;
        r0 = rxCount;
        applyStimulus(mosi, 8, got);
        checkOutput("miso_byte", got, expMiso);
        checkOutput("rx_valid_pulses", rxCount - r0, 1);
        checkOutput("rx_data_at_pulse", lastRxSeen, mosi);
        checkOutput("rx_data", rx_data, mosi);
        mLastRx = mosi;
        modelLoad();
        checkOutput("tx_ready_after_byte", tx_ready, mFull ? 0 : 1);
    endtask

    task automatic abortFrame(input logic [7:0] mosi, input int nBits);
        logic [7:0] got;
        int         r0;
        r0 = rxCount;
        applyStimulus(mosi, nBits, got);
        csHigh(1);
        checkOutput("abort_no_rx_valid", rxCount - r0, 0);
        checkOutput("abort_rx_data_kept", rx_data, mLastRx);
    endtask

    initial begin
        logic [7:0] got;
        int         r0;
        int         e0;
        int         nb;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_miso", dout_miso, 0);
        checkOutput("reset_tx_ready", tx_ready, 1);
        checkOutput("reset_rx_data", rx_data, 0);
        checkOutput("reset_busy", busy, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] back-to-back bytes with no tx data");
        csLow();
        fullByte(8'h00);
        fullByte(8'h01);
        fullByte(8'h02);
        csHigh(0);

        $display("[TB] queued byte 0xF1, receive 0x03");
        loadTx(8'hF1);
        csLow();
        fullByte(8'h03);
        csHigh(0);

        $display("[TB] aborted frame then 0xA5");
        csLow();
        abortFrame(8'h6C, 5);
        csLow();
        fullByte(8'hA5);
        csHigh(0);

        $display("[TB] latest tx_load wins");
        loadTx(8'h11);
        loadTx(8'h22);
        csLow();
        fullByte(8'h3C);
        csHigh(0);

        $display("[TB] tx_load coincident with load on empty buffer");
        @(negedge clk);
        cs_bar = 1'b0;
        repeat (3) @(negedge clk);
        tx_data = 8'h33;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        repeat (7) @(negedge clk);
        mShift = 8'h33;
        mFull  = 1'b0;
        checkOutput("bypass_tx_ready", tx_ready, 1);
        fullByte(8'hC3);
        csHigh(0);

        $display("[TB] tx_load coincident with load on full buffer");
        loadTx(8'h44);
        @(negedge clk);
        cs_bar = 1'b0;
        repeat (3) @(negedge clk);
        tx_data = 8'h55;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        repeat (7) @(negedge clk);
        mShift = 8'h44;
        mBuf   = 8'h55;
        mFull  = 1'b1;
        checkOutput("overwrite_tx_ready", tx_ready, 0);
        fullByte(8'h96);
        fullByte(8'h69);
        csHigh(0);

        $display("[TB] reset mid-frame");
        loadTx(8'hFF);
        csLow();
        r0 = rxCount;
        e0 = errCount;
        applyStimulus(8'h0F, 4, got);
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_miso", dout_miso, mShift[3]);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_miso", dout_miso, 0);
        checkOutput("async_reset_busy", busy, 0);
        checkOutput("async_reset_tx_ready", tx_ready, 1);
        checkOutput("async_reset_rx_data", rx_data, 0);
        checkOutput("async_reset_rx_valid", rx_valid, 0);
        checkOutput("async_reset_frame_err", frame_err, 0);
        cs_bar = 1'b1;
        mFull   = 1'b0;
        mLastRx = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("reset_no_rx_valid", rxCount - r0, 0);
        checkOutput("reset_no_frame_err", errCount - e0, 0);
        csLow();
        fullByte(8'h5A);
        csHigh(0);

        $display("[TB] random frames");
        for (int f = 0; f < 15; f++) begin
            if ($urandom_range(1) == 1) loadTx(8'($urandom));
            if ($urandom_range(3) == 0) loadTx(8'($urandom));
            csLow();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                if (b > 0 && $urandom_range(1) == 1) loadTx(8'($urandom));
                fullByte(8'($urandom));
            end
            if ($urandom_range(3) == 0) abortFrame(8'($urandom), $urandom_range(1, 7));
            else csHigh(0);
        end

        checkOutput("no_coincident_pulses", bothCount, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
